// File: rtl/dmac_cfg_arb.sv
// Two-requester arbiter in front of a config register port: one command per 3 cycles.
// Define DMAC_CFG_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module dmac_cfg_arb (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid_i,
    input  logic        req0_write_i,
    input  logic [31:0] req0_wdata_i,
    output logic        req0_ready_o,
    output logic        rsp0_valid_o,
    output logic [31:0] rsp0_rdata_o,
    input  logic        req1_valid_i,
    input  logic        req1_write_i,
    input  logic [31:0] req1_wdata_i,
    output logic        req1_ready_o,
    output logic        rsp1_valid_o,
    output logic [31:0] rsp1_rdata_o,
    output logic        wren_o,
    output logic        rden_o,
    output logic [31:0] wdata_o,
    input  logic [31:0] rdata_i
);

    // state | meaning
    // IDLE  | arbitrate, grant one valid requester
    // ISSUE | drive wren_o/rden_o from captured command
    // RESP  | pulse response to the granted requester
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t      state, state_nxt;
    logic        prio;
    logic        any_valid;
    logic        win;
    logic        hs;
    logic        gnt_q;
    logic        wr_q;
    logic [31:0] wdata_q;

    assign any_valid = req0_valid_i | req1_valid_i;

`ifdef DMAC_CFG_ARB_FIXED_PRIO_EN
    assign win = !req0_valid_i;
`else
    assign win = (req0_valid_i && req1_valid_i) ? prio : req1_valid_i;
`endif

    assign hs = (state == IDLE) && any_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_valid) state_nxt = ISSUE;
            ISSUE:   state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio    <= 1'b0;
            gnt_q   <= 1'b0;
            wr_q    <= 1'b0;
            wdata_q <= 32'h0;
        end else if (hs) begin
            gnt_q   <= win;
            wr_q    <= win ? req1_write_i : req0_write_i;
            wdata_q <= win ? req1_wdata_i : req0_wdata_i;
`ifdef DMAC_CFG_ARB_FIXED_PRIO_EN
            prio    <= 1'b0;
`else
            prio    <= !win;
`endif
        end
    end

    // Ready is gated by rst so it stays low for the whole reset pulse.
    always_comb begin
        req0_ready_o = !rst && hs && !win;
        req1_ready_o = !rst && hs && win;
        wren_o       = 1'b0;
        rden_o       = 1'b0;
        wdata_o      = 32'h0;
        rsp0_valid_o = 1'b0;
        rsp0_rdata_o = 32'h0;
        rsp1_valid_o = 1'b0;
        rsp1_rdata_o = 32'h0;
        case (state)
            ISSUE: begin
                wren_o  = wr_q;
                rden_o  = !wr_q;
                wdata_o = wr_q ? wdata_q : 32'h0;
            end
            RESP: begin
                if (gnt_q) begin
                    rsp1_valid_o = 1'b1;
                    rsp1_rdata_o = wr_q ? 32'h0 : rdata_i;
                end else begin
                    rsp0_valid_o = 1'b1;
                    rsp0_rdata_o = wr_q ? 32'h0 : rdata_i;
                end
            end
            default: ;
        endcase
    end

endmodule
